// File: rtl/al422_bam_writer.sv
// Write-side sequencer: rewinds the AL422, then streams one header+pixel record
// per (row, bitplane) pair from the frame buffer into the AL422 write port.
module al422_bam_writer #(
    parameter int unsigned COLS        = 64,
    parameter int unsigned ROWS        = 32,
    parameter int unsigned BITS        = 8,
    parameter int unsigned WRST_CYCLES = 4,
    localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned PW  = (BITS > 1) ? $clog2(BITS) : 1,
    localparam int unsigned AW  = RW + CW,
    localparam int unsigned KM0 = (COLS > WRST_CYCLES) ? COLS : WRST_CYCLES,
    localparam int unsigned KW  = $clog2((KM0 > 5) ? KM0 : 5)
) (
    input  logic          in_clk,
    input  logic          in_nrst,
    input  logic          start,
    input  logic [15:0]   cfg_base_time,
    input  logic [15:0]   cfg_inactive_time,
    input  logic          cfg_oe_inv,
    output logic [AW-1:0] fb_addr,
    input  logic [47:0]   fb_data,
    output logic          al422_wrst_out,
    output logic          al422_we_out,
    output logic [7:0]    al422_data_out,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [2:0] {IDLE, WRST, HDR, PIX, DONE} state_t;

    state_t        state, state_n;
    logic [KW-1:0] cnt, cnt_n;
    logic [RW-1:0] row, row_n;
    logic [PW-1:0] plane, plane_n;
    logic [15:0]   base_q, base_n;
    logic [15:0]   inact_q, inact_n;
    logic          oe_q, oe_n;
    logic          wrst_n, we_n, busy_n, done_n;
    logic [7:0]    byte_q, byte_n;
    logic          pix_q, pix_n;
    logic          last_col_q, last_col_n;
    logic          last_frame_q, last_frame_n;
    logic [AW-1:0] addr_n;
    logic [23:0]   act_wide;
    logic [15:0]   act_sat;
    logic [2:0]    pidx;
    logic [7:0]    pix_byte;

    function automatic logic [7:0] h0_byte(input logic oe, input logic [RW-1:0] r);
        return {2'b00, oe, 5'(r)};
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] act,
                                            input logic [15:0] inact);
        case (idx)
            3'd1:    return act[7:0];
            3'd2:    return act[15:8];
            3'd3:    return inact[7:0];
            3'd4:    return inact[15:8];
            default: return 8'h00;
        endcase
    endfunction

    // Per-plane active time, saturated to 16 bits
    always_comb begin
        act_wide = {8'h00, base_q} << plane;
        act_sat  = (act_wide[23:16] != 8'h00) ? 16'hFFFF : act_wide[15:0];
    end

    // Pixel bytes come straight from the frame buffer read port, which returns data
    // in the very cycle the byte is written; header/idle bytes come from byte_q.
    assign pidx     = 3'(plane);
    assign pix_byte = {last_frame_q, last_col_q,
                       fb_data[24 + 32'(pidx)], fb_data[32 + 32'(pidx)], fb_data[40 + 32'(pidx)],
                       fb_data[0 + 32'(pidx)],  fb_data[8 + 32'(pidx)],  fb_data[16 + 32'(pidx)]};
    assign al422_data_out = pix_q ? pix_byte : byte_q;

    // Next-state and next-output logic; outputs are computed for the coming cycle
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        row_n        = row;
        plane_n      = plane;
        base_n       = base_q;
        inact_n      = inact_q;
        oe_n         = oe_q;
        wrst_n       = 1'b1;
        we_n         = al422_we_out;
        busy_n       = busy;
        done_n       = 1'b0;
        byte_n       = byte_q;
        pix_n        = pix_q;
        last_col_n   = 1'b0;
        last_frame_n = 1'b0;
        addr_n       = fb_addr;

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                we_n    = 1'b1;
                byte_n  = 8'h00;
                pix_n   = 1'b0;
                busy_n  = 1'b0;
                if (start) begin
                    state_n = WRST;
                    cnt_n   = '0;
                    wrst_n  = 1'b0;
                    busy_n  = 1'b1;
                    base_n  = cfg_base_time;
                    inact_n = cfg_inactive_time;
                    oe_n    = cfg_oe_inv;
                end
            end
            WRST: begin
                if (cnt == KW'(WRST_CYCLES - 1)) begin
                    state_n = HDR;
                    cnt_n   = '0;
                    row_n   = '0;
                    plane_n = '0;
                    we_n    = 1'b0;
                    byte_n  = h0_byte(oe_q, '0);
                end else begin
                    cnt_n  = cnt + KW'(1);
                    wrst_n = 1'b0;
                end
            end
            HDR: begin
                if (cnt == KW'(3)) begin
                    addr_n = {row, CW'(0)};
                end
                if (cnt == KW'(4)) begin
                    state_n = PIX;
                    cnt_n   = '0;
                    pix_n   = 1'b1;
                    addr_n  = {fb_addr[AW-1:CW], fb_addr[CW-1:0] + CW'(1)};
                end else begin
                    cnt_n  = cnt + KW'(1);
                    byte_n = hdr_byte(3'(cnt + KW'(1)), act_sat, inact_q);
                end
            end
            PIX: begin
                addr_n = {fb_addr[AW-1:CW], fb_addr[CW-1:0] + CW'(1)};
                if (cnt == KW'(COLS - 1)) begin
                    pix_n = 1'b0;
                    cnt_n = '0;
                    if (plane != PW'(BITS - 1)) begin
                        state_n = HDR;
                        plane_n = plane + PW'(1);
                        byte_n  = h0_byte(oe_q, row);
                    end else if (row != RW'(ROWS - 1)) begin
                        state_n = HDR;
                        plane_n = '0;
                        row_n   = row + RW'(1);
                        byte_n  = h0_byte(oe_q, row + RW'(1));
                    end else begin
                        state_n = DONE;
                        we_n    = 1'b1;
                        byte_n  = 8'h00;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n        = cnt + KW'(1);
                    last_col_n   = (cnt == KW'(COLS - 2));
                    last_frame_n = (cnt == KW'(COLS - 2)) && (row == RW'(ROWS - 1))
                                   && (plane == PW'(BITS - 1));
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge in_clk) begin
        if (!in_nrst) begin
            state          <= IDLE;
            cnt            <= '0;
            row            <= '0;
            plane          <= '0;
            base_q         <= '0;
            inact_q        <= '0;
            oe_q           <= 1'b0;
            al422_wrst_out <= 1'b1;
            al422_we_out   <= 1'b1;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            byte_q         <= '0;
            pix_q          <= 1'b0;
            last_col_q     <= 1'b0;
            last_frame_q   <= 1'b0;
            fb_addr        <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            row            <= row_n;
            plane          <= plane_n;
            base_q         <= base_n;
            inact_q        <= inact_n;
            oe_q           <= oe_n;
            al422_wrst_out <= wrst_n;
            al422_we_out   <= we_n;
            busy           <= busy_n;
            frame_done     <= done_n;
            byte_q         <= byte_n;
            pix_q          <= pix_n;
            last_col_q     <= last_col_n;
            last_frame_q   <= last_frame_n;
            fb_addr        <= addr_n;
        end
    end

endmodule

// File: tb/tb_al422_bam_writer.sv
// Scoreboard bench for al422_bam_writer: two instances (BITS=2 and BITS=4) on a
// shared clock, each reading a small frame-buffer RAM with one cycle read latency.
module tb_al422_bam_writer;

    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          nrst, start_a, start_s, oe, sel;
    logic [15:0]   base, inact;
    logic [AW-1:0] addr_a, addr_s;
    logic [47:0]   fbd_a, fbd_s;
    logic          wrst_a, we_a, busy_a, done_a, wrst_s, we_s, busy_s, done_s;
    logic [7:0]    data_a, data_s;
    logic          m_we, m_wrst, m_busy, m_done;
    logic [7:0]    m_data;

    logic [47:0]   mem [0:7];
    logic [7:0]    exp_q[$];
    logic [7:0]    got_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;

    // Frame-buffer RAM model: data valid the cycle after the address
    always @(posedge clk) begin
        fbd_a <= mem[addr_a];
        fbd_s <= mem[addr_s];
    end

    assign m_we   = sel ? we_s   : we_a;
    assign m_wrst = sel ? wrst_s : wrst_a;
    assign m_busy = sel ? busy_s : busy_a;
    assign m_done = sel ? done_s : done_a;
    assign m_data = sel ? data_s : data_a;

    al422_bam_writer #(.COLS(4), .ROWS(2), .BITS(2), .WRST_CYCLES(4)) dut_a (
        .in_clk(clk), .in_nrst(nrst), .start(start_a), .cfg_base_time(base),
        .cfg_inactive_time(inact), .cfg_oe_inv(oe), .fb_addr(addr_a), .fb_data(fbd_a),
        .al422_wrst_out(wrst_a), .al422_we_out(we_a), .al422_data_out(data_a),
        .busy(busy_a), .frame_done(done_a));

    al422_bam_writer #(.COLS(4), .ROWS(2), .BITS(4), .WRST_CYCLES(4)) dut_s (
        .in_clk(clk), .in_nrst(nrst), .start(start_s), .cfg_base_time(base),
        .cfg_inactive_time(inact), .cfg_oe_inv(oe), .fb_addr(addr_s), .fb_data(fbd_s),
        .al422_wrst_out(wrst_s), .al422_we_out(we_s), .al422_data_out(data_s),
        .busy(busy_s), .frame_done(done_s));

    // Reference model: push every byte of one frame (2 rows x bits planes x 4 cols)
    task automatic push_frame(input int bits);
        logic [23:0] at;
        logic [47:0] w;
        logic [7:0]  p;
        exp_q.delete();
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < bits; b++) begin
                at = 24'(base) << b;
                if (at > 24'h00FFFF) at = 24'h00FFFF;
                exp_q.push_back({2'b00, oe, 5'(r)});
                exp_q.push_back(at[7:0]);
                exp_q.push_back(at[15:8]);
                exp_q.push_back(inact[7:0]);
                exp_q.push_back(inact[15:8]);
                for (int c = 0; c < 4; c++) begin
                    w = mem[r * 4 + c];
                    p[0] = w[16 + b];
                    p[1] = w[8 + b];
                    p[2] = w[b];
                    p[3] = w[40 + b];
                    p[4] = w[32 + b];
                    p[5] = w[24 + b];
                    p[6] = (c == 3);
                    p[7] = (c == 3) && (r == 1) && (b == bits - 1);
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    // Record one frame's writes and timing (cycle k = k clocks after the start cycle)
    task automatic capture(input bit do_start, input int budget, input int extra_k,
                           output int t_wrst, output int n_wrst, output int t_h0,
                           output int t_last, output int t_done, output bit busy1);
        got_q.delete();
        t_wrst = -1; n_wrst = 0; t_h0 = -1; t_last = -1; t_done = -1; busy1 = 1'b0;
        if (do_start) begin
            if (sel) start_s = 1'b1; else start_a = 1'b1;
        end
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start_a = !sel && (k == extra_k);
            start_s = sel && (k == extra_k);
            if (k == 1) busy1 = m_busy;
            if (!m_wrst) begin
                n_wrst++;
                if (t_wrst < 0) t_wrst = k;
            end
            if (!m_we) begin
                got_q.push_back(m_data);
                if (t_h0 < 0) t_h0 = k;
                t_last = k;
            end
            if (m_done) begin
                t_done = k;
                break;
            end
        end
        start_a = 1'b0;
        start_s = 1'b0;
    endtask

    task automatic test_reset();
        int lows;
        nrst = 1'b0; start_a = 1'b1; start_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({wrst_a, we_a, data_a, addr_a, busy_a, done_a} !== {1'b1, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_values cyc%0d: got wrst=%b we=%b data=%h addr=%h busy=%b done=%b, need 1 1 00 0 0 0",
                         i, wrst_a, we_a, data_a, addr_a, busy_a, done_a);
            end
        end
        start_a = 1'b0; start_s = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!we_a || !wrst_a || busy_a || !we_s || !wrst_s) lows++;
        end
        n_cmp++;
        if (lows !== 0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: got %0d active cycles, need 0", lows);
        end
    endtask

    task automatic test_header_pixels();
        int t_wrst, n_wrst, t_h0, t_last, t_done;
        bit busy1;
        int idx[15] = '{0, 1, 2, 3, 4, 9, 10, 11, 12, 13, 18, 5, 14, 8, 35};
        logic [7:0] val[15] = '{8'h20, 8'h03, 8'h00, 8'h05, 8'h00, 8'h20, 8'h06, 8'h00,
                                8'h05, 8'h00, 8'h21, 8'h01, 8'h20, 8'h40, 8'hC0};
        logic [7:0] e, g;
        sel = 1'b0;
        for (int r = 0; r < 2; r++) begin
            mem[r * 4 + 0] = {24'h000002, 24'h010000};
            mem[r * 4 + 1] = {16'($urandom), 32'($urandom)};
            mem[r * 4 + 2] = {16'($urandom), 32'($urandom)};
            mem[r * 4 + 3] = 48'h0;
        end
        base = 16'd3; inact = 16'd5; oe = 1'b1;
        push_frame(2);
        capture(1'b1, 200, -1, t_wrst, n_wrst, t_h0, t_last, t_done, busy1);
        n_cmp++; if (t_done !== 41) begin n_fail++; $display("FAIL done_latency: got %0d, need 41", t_done); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b, need 0", busy_a); end
        n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b, need 1", busy1); end
        n_cmp++; if (t_wrst !== 1 || n_wrst !== 4) begin n_fail++; $display("FAIL wrst_pulse: got start %0d len %0d, need 1 4", t_wrst, n_wrst); end
        n_cmp++; if (t_h0 !== 5) begin n_fail++; $display("FAIL first_h0_cycle: got %0d, need 5", t_h0); end
        n_cmp++; if (t_last !== 40 || got_q.size() !== 36) begin n_fail++; $display("FAIL byte_count: got last %0d n %0d, need 40 36", t_last, got_q.size()); end
        for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if (got_q.size() <= idx[i]) begin
                n_fail++; $display("FAIL spot_byte[%0d]: got none, need %h", idx[i], val[i]);
            end else if (got_q[idx[i]] !== val[i]) begin
                n_fail++; $display("FAIL spot_byte[%0d]: got %h, need %h", idx[i], got_q[idx[i]], val[i]);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL frame_byte: got none, need %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL frame_byte: got %h, need %h", g, e); end
            end
        end
    endtask

    task automatic test_saturation();
        int t_wrst, n_wrst, t_h0, t_last, t_done;
        bit busy1;
        logic [15:0] at[4] = '{16'h4000, 16'h8000, 16'hFFFF, 16'hFFFF};
        logic [7:0] e, g;
        sel = 1'b1;
        base = 16'h4000; inact = 16'h1234; oe = 1'b0;
        push_frame(4);
        capture(1'b1, 300, -1, t_wrst, n_wrst, t_h0, t_last, t_done, busy1);
        n_cmp++; if (t_done !== 77) begin n_fail++; $display("FAIL sat_done_latency: got %0d, need 77", t_done); end
        for (int b = 0; b < 4; b++) begin
            n_cmp++;
            if (got_q.size() < 9 * b + 3) begin
                n_fail++; $display("FAIL sat_active[%0d]: got none, need %h", b, at[b]);
            end else if ({got_q[9 * b + 2], got_q[9 * b + 1]} !== at[b]) begin
                n_fail++; $display("FAIL sat_active[%0d]: got %h%h, need %h", b, got_q[9 * b + 2], got_q[9 * b + 1], at[b]);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL sat_frame_byte: got none, need %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL sat_frame_byte: got %h, need %h", g, e); end
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_start_busy();
        int t_wrst, n_wrst, t_h0, t_last, t_done, act;
        bit busy1;
        logic [7:0] e, g;
        sel = 1'b0;
        base = 16'd7; inact = 16'd9; oe = 1'b0;
        push_frame(2);
        capture(1'b1, 200, 10, t_wrst, n_wrst, t_h0, t_last, t_done, busy1);
        n_cmp++; if (n_wrst !== 4 || t_done !== 41) begin n_fail++; $display("FAIL start_while_busy: got wrst %0d done %0d, need 4 41", n_wrst, t_done); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL busy_frame_byte: got none, need %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL busy_frame_byte: got %h, need %h", g, e); end
            end
        end
        act = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!we_a || !wrst_a || busy_a) act++;
        end
        n_cmp++; if (act !== 0) begin n_fail++; $display("FAIL idle_after_frame: got %0d active cycles, need 0", act); end
    endtask

    task automatic test_back_to_back();
        int t_wrst, n_wrst, t_h0, t_last, t_done;
        bit busy1;
        logic [7:0] e, g;
        sel = 1'b0;
        base = 16'd2; inact = 16'd1; oe = 1'b1;
        capture(1'b1, 200, -1, t_wrst, n_wrst, t_h0, t_last, t_done, busy1);
        n_cmp++; if (t_done !== 41) begin n_fail++; $display("FAIL b2b_first_done: got %0d, need 41", t_done); end
        base = 16'h0100; inact = 16'hABCD; oe = 1'b0;
        push_frame(2);
        start_a = 1'b1;
        capture(1'b0, 200, -1, t_wrst, n_wrst, t_h0, t_last, t_done, busy1);
        n_cmp++; if (t_wrst !== 1 || busy1 !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got wrst at %0d busy %b, need 1 1", t_wrst, busy1); end
        n_cmp++; if (t_h0 !== 5 || t_done !== 41) begin n_fail++; $display("FAIL b2b_timing: got h0 %0d done %0d, need 5 41", t_h0, t_done); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL b2b_frame_byte: got none, need %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL b2b_frame_byte: got %h, need %h", g, e); end
            end
        end
    endtask

    task automatic test_mid_reset();
        int t_wrst, n_wrst, t_h0, t_last, t_done;
        bit busy1;
        logic [7:0] e, g;
        sel = 1'b0;
        base = 16'd3; inact = 16'd5; oe = 1'b1;
        start_a = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        n_cmp++; if (we_a !== 1'b0) begin n_fail++; $display("FAIL mid_we_in_pix: got %b, need 0", we_a); end
        nrst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({we_a, wrst_a, busy_a} !== 3'b110) begin
                n_fail++; $display("FAIL mid_reset_stop cyc%0d: got we=%b wrst=%b busy=%b, need 1 1 0", i, we_a, wrst_a, busy_a);
            end
        end
        nrst = 1'b1;
        @(negedge clk);
        push_frame(2);
        capture(1'b1, 200, -1, t_wrst, n_wrst, t_h0, t_last, t_done, busy1);
        n_cmp++; if (t_wrst !== 1 || n_wrst !== 4 || t_h0 !== 5) begin n_fail++; $display("FAIL mid_restart: got wrst %0d/%0d h0 %0d, need 1/4 5", t_wrst, n_wrst, t_h0); end
        n_cmp++; if (got_q.size() == 0 || got_q[0] !== 8'h20) begin n_fail++; $display("FAIL mid_restart_h0: got %h, need 20", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL mid_frame_byte: got none, need %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL mid_frame_byte: got %h, need %h", g, e); end
            end
        end
    endtask

    initial begin
        sel = 1'b0; nrst = 1'b0; start_a = 1'b0; start_s = 1'b0;
        base = 16'h0; inact = 16'h0; oe = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 48'h0;
        test_reset();
        test_header_pixels();
        test_saturation();
        test_start_busy();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
